// File: rtl/reg_dump_streamer_if.sv
// ---------------------------------------------------------------------------
// reg_dump_streamer_if
// Byte-wide valid/ready stream carrying the register dump.
//   tx_data  : current stream byte (source -> sink)
//   tx_valid : tx_data is valid (source -> sink)
//   tx_ready : sink accepts the byte this edge (sink -> source)
// A byte transfers on a rising edge where tx_valid && tx_ready.
// master = byte source (the streamer), slave = byte sink.
// ---------------------------------------------------------------------------
interface reg_dump_streamer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/reg_dump_streamer.sv
// ---------------------------------------------------------------------------
// reg_dump_streamer
// Walks the register file through its view port and streams every register
// in [first_addr .. last_addr] (wrapping past the top index) as a frame of
// one index byte followed by DATA_WIDTH/8 data bytes, LSB byte first.
// Read-only towards the register file.
//
// Ports:
//   CLK        : clock, rising edge
//   RST_N      : asynchronous active-low reset
//   start      : request a dump, only honoured while idle
//   first_addr : first register index, latched with start
//   last_addr  : last register index, latched with start
//   view_addr  : register index presented to the register file
//   view_data  : combinational read data for view_addr
//   tx         : byte stream source (tx_data / tx_valid / tx_ready)
//   busy       : dump in progress
//   done       : one-cycle pulse after the final byte transfers
// ---------------------------------------------------------------------------
module reg_dump_streamer #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] first_addr,
  input  logic [ADDRESS_WIDTH-1:0] last_addr,
  output logic [ADDRESS_WIDTH-1:0] view_addr,
  input  logic [DATA_WIDTH-1:0]    view_data,
  reg_dump_streamer_if.master      tx,
  output logic                     busy,
  output logic                     done
);

  localparam int NBYTES = DATA_WIDTH / 8;
  // Keep the byte counter at least one bit wide even for 8-bit registers.
  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND_IDX,
    SEND_DATA
  } state_t;

  state_t                   state;
  logic [DATA_WIDTH-1:0]    shift_q;
  logic [ADDRESS_WIDTH-1:0] cur;
  logic [ADDRESS_WIDTH-1:0] last_q;
  logic [CNT_W-1:0]         cnt;

  // Snapshot after the current byte leaves; its low byte is the next one out.
  logic [DATA_WIDTH-1:0]    shift_next;
  assign shift_next = shift_q >> 8;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      shift_q     <= '0;
      cur         <= '0;
      last_q      <= '0;
      cnt         <= '0;
      view_addr   <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            last_q    <= last_addr;
            cur       <= first_addr;
            view_addr <= first_addr;
            busy      <= 1'b1;
            state     <= CAPTURE;
          end
        end

        CAPTURE: begin
          // view_addr has been stable a full cycle; freeze this register now.
          shift_q     <= view_data;
          tx.tx_data  <= 8'(cur);
          tx.tx_valid <= 1'b1;
          state       <= SEND_IDX;
        end

        SEND_IDX: begin
          if (tx.tx_ready) begin
            tx.tx_data <= shift_q[7:0];
            cnt        <= '0;
            state      <= SEND_DATA;
          end
        end

        SEND_DATA: begin
          if (tx.tx_ready) begin
            shift_q <= shift_next;
            cnt     <= cnt + CNT_W'(1);
            if (cnt == LAST_BYTE) begin
              tx.tx_valid <= 1'b0;
              if (cur == last_q) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                // Natural modulo wrap of the index gives the wrap-around walk.
                cur       <= cur + ADDRESS_WIDTH'(1);
                view_addr <= cur + ADDRESS_WIDTH'(1);
                state     <= CAPTURE;
              end
            end else begin
              tx.tx_data <= shift_next[7:0];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_streamer
// Drives dumps against a register-file array and compares the transferred
// byte stream, view_addr walk, busy/done timing and stall behaviour with a
// list-level reference built from the dump rules.
// ---------------------------------------------------------------------------
module tb_reg_dump_streamer;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  view_addr;
  logic [31:0] view_data;
  logic        busy;
  logic        done;

  reg_dump_streamer_if tx_if ();

  logic [31:0] regs  [32];
  logic [31:0] model [32];

  int n_checks;
  int n_pass;

  assign view_data = regs[view_addr];

  reg_dump_streamer #(
    .ADDRESS_WIDTH (5),
    .DATA_WIDTH    (32)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .view_addr  (view_addr),
    .view_data  (view_data),
    .tx         (tx_if),
    .busy       (busy),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One full dump. Expected frames come from 'model'; snap applies register
  // writes in the middle of x6's data bytes; extra_start pulses start while busy.
  task automatic run_dump(input int f, input int l, input bit rnd_ready,
                          input bit snap, input bit extra_start, input string name);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         exp_addr[$];
    int         got_addr[$];
    int         a, e, done_e, nregs;
    bit         busy_ok, stall_ok, prev_stall, busy_at_done;
    logic [7:0] prev_data;
    logic [4:0] prev_view;

    a = f;
    nregs = 0;
    forever begin
      exp_addr.push_back(a);
      exp_q.push_back(8'(a));
      for (int b = 0; b < 4; b++) exp_q.push_back(model[a][8*b +: 8]);
      nregs++;
      if (a == l) break;
      a = (a + 1) % 32;
    end

    @(negedge CLK);
    first_addr = 5'(f);
    last_addr  = 5'(l);
    start      = 1'b1;
    tx_if.tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge CLK);
    start = 1'b0;

    e = 0;
    done_e = -1;
    busy_ok = 1'b1;
    stall_ok = 1'b1;
    prev_stall = 1'b0;
    busy_at_done = 1'b0;
    prev_data = '0;
    prev_view = '0;
    while (done_e < 0 && e < 4000) begin
      if (done) begin
        done_e = e;
        busy_at_done = busy;
      end else begin
        if (!busy) busy_ok = 1'b0;
        if (got_addr.size() == 0 || got_addr[$] != int'(view_addr))
          got_addr.push_back(int'(view_addr));
        if (prev_stall && (!tx_if.tx_valid || tx_if.tx_data != prev_data || view_addr != prev_view))
          stall_ok = 1'b0;
        if (snap && e == 9) begin
          regs[6] = 32'h11111111;
          regs[7] = 32'hC0FFEE77;
        end
        if (extra_start && e == 3) begin
          start      = 1'b1;
          first_addr = 5'($urandom_range(0, 31));
          last_addr  = 5'($urandom_range(0, 31));
        end else begin
          start = 1'b0;
        end
        tx_if.tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tx_if.tx_valid && tx_if.tx_ready) got_q.push_back(tx_if.tx_data);
        prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
        prev_data  = tx_if.tx_data;
        prev_view  = view_addr;
      end
      @(negedge CLK);
      e++;
    end

    check({name, " done_seen"}, 32'(done_e >= 0), 32'd1);
    if (!rnd_ready) check({name, " done_cycle"}, 32'(done_e), 32'(6 * nregs));
    check({name, " busy_window"}, 32'(busy_ok), 32'd1);
    check({name, " busy_at_done"}, 32'(busy_at_done), 32'd0);
    check({name, " done_one_cycle"}, 32'(done), 32'd0);
    check({name, " valid_after"}, 32'(tx_if.tx_valid), 32'd0);
    if (rnd_ready) check({name, " stall_hold"}, 32'(stall_ok), 32'd1);
    check({name, " byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({name, " addr_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      check($sformatf("%s view_addr%0d", name, i), 32'(got_addr[i]), 32'(exp_addr[i]));
    $display("dump %s first=%0d last=%0d regs=%0d bytes=%0d done_at=%0d", name, f, l, nregs,
             got_q.size(), done_e);
    start = 1'b0;
    tx_if.tx_ready = 1'b1;
  endtask

  initial begin
    int f, l;
    n_checks = 0;
    n_pass   = 0;
    RST_N = 1'b0;
    start = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;

    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("reset view_addr", 32'(view_addr), 32'd0);
    check("reset tx_data", 32'(tx_if.tx_data), 32'd0);
    check("reset tx_valid", 32'(tx_if.tx_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    $display("reset state checked");

    // Single register with known contents.
    regs[10] = 32'hDEADBEEF;
    model = regs;
    run_dump(10, 10, 1'b0, 1'b0, 1'b0, "single");

    // Full dump with patterned contents.
    for (int k = 0; k < 32; k++) regs[k] = 32'h01010101 * k;
    model = regs;
    run_dump(0, 31, 1'b0, 1'b0, 1'b0, "full");

    // Wrap-around walk.
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    model = regs;
    run_dump(30, 1, 1'b0, 1'b0, 1'b0, "wrap");

    // Backpressure plus an ignored start while busy.
    model = regs;
    run_dump(5, 7, 1'b1, 1'b0, 1'b1, "backpressure");

    // Snapshot: x6 written after capture keeps old bytes, x7 written before
    // its capture shows the new value.
    model = regs;
    model[7] = 32'hC0FFEE77;
    run_dump(5, 7, 1'b0, 1'b1, 1'b0, "snapshot");

    // Asynchronous reset in the middle of a data phase.
    @(negedge CLK);
    first_addr = 5'd3;
    last_addr  = 5'd4;
    start = 1'b1;
    tx_if.tx_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("async view_addr", 32'(view_addr), 32'd0);
    check("async tx_data", 32'(tx_if.tx_data), 32'd0);
    check("async tx_valid", 32'(tx_if.tx_valid), 32'd0);
    check("async busy", 32'(busy), 32'd0);
    check("async done", 32'(done), 32'd0);
    $display("asynchronous reset during data phase checked");
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("post reset idle busy", 32'(busy), 32'd0);
    model = regs;
    run_dump(3, 4, 1'b0, 1'b0, 1'b0, "after_reset");

    // Random ranges and random backpressure.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      model = regs;
      f = $urandom_range(0, 31);
      l = $urandom_range(0, 31);
      run_dump(f, l, 1'($urandom_range(0, 1)), 1'b0, 1'b0, $sformatf("random%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
